mult_div_unit: RTL and testbench

Multicycle signed multiply/divide responder for the MIPS datapath. It accepts a one-cycle `start` command from the control unit and computes either a 64-bit signed product or a signed quotient/remainder over 32 iterations. It then presents the result on registered `hi_out`/`lo_out` for the control unit to latch into the Hi/Lo registers (HiWrite/LoWrite), and signals completion with a one-cycle `done` pulse. Divide-by-zero is reported on `div_zero` so the control unit can enter its exception path (EPC).

---
 rtl/mult_div_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mult_div_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed multiply/divide unit for Hi/Lo
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high
//   start     command strobe, sampled only while idle
//   op        0 = MULT, 1 = DIV
//   a, b      signed operands (multiplicand/dividend, multiplier/divisor)
//   busy      high while a command is in progress
//   done      one-cycle completion pulse; hi_out/lo_out valid from this cycle
//   div_zero  high with done when a DIV had a zero divisor
//   hi_out    MULT: product upper half; DIV: remainder
//   lo_out    MULT: product lower half; DIV: quotient

module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic            op_q;
    logic            sign_a;
    logic            sign_b;
    logic [WIDTH:0]  mag_a;
    logic [WIDTH:0]  mag_b;
    logic [AW-1:0]   acc;
    logic [CW-1:0]   count;

    // Control decodes
    logic accept;
    logic zero_div;
    logic last_iter;

    // Operand magnitudes; one extra bit so |-2^(WIDTH-1)| is representable
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] a_mag_in;
    logic [WIDTH:0] b_mag_in;

    // Iteration datapath
    logic [WIDTH+1:0] mul_sum;
    logic [AW-1:0]    mul_next;
    logic [AW-1:0]    div_shift;
    logic [WIDTH+1:0] div_trial;
    logic [AW-1:0]    div_next;

    // Sign fix-up
    logic              neg_result;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = CALC;
            CALC:    if (last_iter) next_state = FIX;
            FIX:                    next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control decode
    // ------------------------------------------------------------------
    always_comb begin
        busy      = (state != IDLE);
        // A zero divisor is answered straight from IDLE without leaving it.
        zero_div  = (state == IDLE) && start && op && (b == '0);
        accept    = (state == IDLE) && start && !(op && (b == '0));
        last_iter = (count == CW'(WIDTH - 1));
    end

    // ------------------------------------------------------------------
    // Combinational arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        a_ext    = {a[WIDTH-1], a};
        b_ext    = {b[WIDTH-1], b};
        a_mag_in = a[WIDTH-1] ? (~a_ext + 1'b1) : a_ext;
        b_mag_in = b[WIDTH-1] ? (~b_ext + 1'b1) : b_ext;

        // Shift-add: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole accumulator right.
        mul_sum  = {1'b0, acc[AW-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // Restoring divide: remainder lives in the upper half, quotient bits
        // shift in at the bottom as the dividend shifts out of the top.
        div_shift = {acc[AW-2:0], 1'b0};
        div_trial = {1'b0, div_shift[AW-1:WIDTH]} - {1'b0, mag_b};
        if (div_trial[WIDTH+1]) begin
            div_next = div_shift;
        end else begin
            div_next = {div_trial[WIDTH:0], div_shift[WIDTH-1:1], 1'b1};
        end

        neg_result  = sign_a ^ sign_b;
        prod_mag    = acc[2*WIDTH-1:0];
        prod_signed = neg_result ? (~prod_mag + 1'b1) : prod_mag;
        quo_mag     = acc[WIDTH-1:0];
        rem_mag     = acc[2*WIDTH-1:WIDTH];
        quo_signed  = neg_result ? (~quo_mag + 1'b1) : quo_mag;
        // Remainder follows the dividend so that quotient truncates to zero.
        rem_signed  = sign_a ? (~rem_mag + 1'b1) : rem_mag;
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            acc      <= '0;
            count    <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;

            if (zero_div) begin
                done     <= 1'b1;
                div_zero <= 1'b1;
            end

            if (accept) begin
                op_q   <= op;
                sign_a <= a[WIDTH-1];
                sign_b <= b[WIDTH-1];
                mag_a  <= a_mag_in;
                mag_b  <= b_mag_in;
                count  <= '0;
                // DIV starts with the dividend in the quotient half so it can
                // be shifted into the remainder one bit per step.
                acc    <= op ? {{(WIDTH + 1){1'b0}}, a_mag_in[WIDTH-1:0]} : '0;
            end

            if (state == CALC) begin
                count <= count + 1'b1;
                if (op_q) begin
                    acc <= div_next;
                end else begin
                    acc   <= mul_next;
                    mag_b <= mag_b >> 1;
                end
            end

            if (state == FIX) begin
                done <= 1'b1;
                if (op_q) begin
                    hi_out <= rem_signed;
                    lo_out <= quo_signed;
                end else begin
                    hi_out <= prod_signed[2*WIDTH-1:WIDTH];
                    lo_out <= prod_signed[WIDTH-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit

module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total;
    int bad;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Called at a negedge: drive a command for one rising edge (E0), return
    // at the negedge right after E0 with start low and operands scrambled.
    task automatic issue(input logic o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        a     = $urandom;
        b     = $urandom;
    endtask

    // Starting at edge index k0 (observed after E<k0>), wait for done.
    // Returns the edge index at which done was seen and count of cycles
    // before done where busy was low.
    task automatic wait_done(input int k0, output int lat, output int busy_low);
        int k;
        k        = k0;
        busy_low = 0;
        while (!done && k < 60) begin
            if (!busy) busy_low++;
            @(negedge clk);
            k++;
        end
        lat = k;
    endtask

    initial begin
        int lat;
        int busy_low;
        int seen;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0]  = '{"mul_7_m3",     1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
        vecs[1]  = '{"mul_max_max",  1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
        vecs[2]  = '{"mul_min_min",  1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
        vecs[3]  = '{"div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
        vecs[4]  = '{"div_100_7",    1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
        vecs[5]  = '{"div_3412_100", 1'b1, 32'h3412,     32'h100,      32'h12,       32'h34,       1'b0, 33};
        vecs[6]  = '{"div_zero",     1'b1, 32'd55,       32'd0,        32'h12,       32'h34,       1'b1, 0};
        vecs[7]  = '{"div_min_m1",   1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
        vecs[8]  = '{"mul_b_zero",   1'b0, 32'd5,        32'd0,        32'h00000000, 32'h00000000, 1'b0, 33};
        vecs[9]  = '{"div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
        vecs[10] = '{"mul_m1_m1",    1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 33};

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dz",   {31'd0, div_zero}, 32'd0);
        check("rst_hi",   hi_out, 32'd0);
        check("rst_lo",   lo_out, 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(0, lat, busy_low);
            check({vecs[i].name, "_lat"},     lat, vecs[i].lat);
            check({vecs[i].name, "_busylow"}, busy_low, 0);
            check({vecs[i].name, "_busy"},    {31'd0, busy}, 32'd0);
            check({vecs[i].name, "_dz"},      {31'd0, div_zero}, {31'd0, vecs[i].dz});
            check({vecs[i].name, "_hi"},      hi_out, vecs[i].hi);
            check({vecs[i].name, "_lo"},      lo_out, vecs[i].lo);
            @(negedge clk);
            check({vecs[i].name, "_pulse"},   {31'd0, done}, 32'd0);
            check({vecs[i].name, "_hold_hi"}, hi_out, vecs[i].hi);
            check({vecs[i].name, "_hold_lo"}, lo_out, vecs[i].lo);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        issue(1'b1, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'd3;
        b     = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, lat, busy_low);
        check("busy_start_lat", lat, 33);
        check("busy_start_hi",  hi_out, 32'd2);
        check("busy_start_lo",  lo_out, 32'd14);
        issue(1'b0, 32'd3, 32'd3);
        wait_done(0, lat, busy_low);
        check("done_cycle_start_lat", lat, 33);
        check("done_cycle_start_busylow", busy_low, 0);
        check("done_cycle_start_hi", hi_out, 32'd0);
        check("done_cycle_start_lo", lo_out, 32'd9);
        @(negedge clk);

        // Reset mid-operation aborts without a done pulse.
        issue(1'b0, 32'd7, 32'hFFFFFFFD);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi",   hi_out, 32'd0);
        check("abort_lo",   lo_out, 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || div_zero || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        issue(1'b0, 32'd6, 32'd7);
        wait_done(0, lat, busy_low);
        check("after_abort_lat", lat, 33);
        check("after_abort_hi",  hi_out, 32'd0);
        check("after_abort_lo",  lo_out, 32'd42);
        check("after_abort_dz",  {31'd0, div_zero}, 32'd0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
